// File: rtl/mem_bridge_if.sv
// Control-unit side of the memory bridge: request levels, store data and the
// shared-bus return path.
interface mem_bridge_if;
    logic [31:0] addr;
    logic [31:0] bus_in;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_size;
    logic        mem_addr_ready;
    logic        mem_data_ready;
    logic [31:0] bus_out;
    logic        bus_oe;
    logic        busy;

    modport master (
        output addr, bus_in, mem_read, mem_write, mem_size, mem_addr_ready,
        input  mem_data_ready, bus_out, bus_oe, busy
    );

    modport slave (
        input  addr, bus_in, mem_read, mem_write, mem_size, mem_addr_ready,
        output mem_data_ready, bus_out, bus_oe, busy
    );
endinterface

// File: rtl/mem_bridge.sv
// Memory stage bridge: serialises control-unit loads/stores into byte beats on
// a byte-wide synchronous SRAM and returns extended load data on the shared bus.
module mem_bridge #(
    parameter int unsigned AW          = 19,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          reset,
    mem_bridge_if.slave   bus,
    output logic [AW-1:0] sram_addr,
    output logic [7:0]    sram_wdata,
    input  logic [7:0]    sram_rdata,
    output logic          sram_oe,
    output logic          sram_we
);

    localparam int unsigned   WCW   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    state_t        state;
    logic [AW-1:0] base;
    logic [31:0]   wdata;
    logic [31:0]   rbuf;
    logic [3:0]    size;
    logic [1:0]    last;
    logic [1:0]    beat;
    logic [WCW-1:0] wcnt;
    logic          mdr;
    logic [31:0]   rdout;

    logic [1:0]    req_last;
    logic [1:0]    beat_nx;
    logic [AW-1:0] addr_nx;
    logic          beat_end;
    logic [31:0]   rword;

    generate
        if (AW < 32) begin : g_addr_hi
            logic addr_hi_unused;
            assign addr_hi_unused = ^bus.addr[31:AW];
        end
    endgenerate

    always_comb begin
        req_last = 2'd3;
        if (bus.mem_size[3] | bus.mem_size[2])
            req_last = 2'd0;
        else if (bus.mem_size[1] | bus.mem_size[0])
            req_last = 2'd1;
    end

    assign beat_nx  = beat + 2'd1;
    assign addr_nx  = base + AW'(beat_nx);
    assign beat_end = (wcnt == WLAST);

    // Word as it will look once the byte ending this beat is captured.
    always_comb begin
        rword = rbuf;
        rword[{beat, 3'b000} +: 8] = sram_rdata;
    end

    function automatic logic [31:0] extend(input logic [3:0] sz, input logic [31:0] w);
        if (sz[3])      return {{24{w[7]}}, w[7:0]};
        else if (sz[2]) return {24'h0, w[7:0]};
        else if (sz[1]) return {{16{w[15]}}, w[15:0]};
        else if (sz[0]) return {16'h0, w[15:0]};
        else            return w;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            base       <= '0;
            wdata      <= '0;
            rbuf       <= '0;
            size       <= '0;
            last       <= '0;
            beat       <= '0;
            wcnt       <= '0;
            mdr        <= 1'b0;
            rdout      <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_oe    <= 1'b0;
            sram_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    wcnt <= '0;
                    if (bus.mem_write) begin
                        state      <= WR;
                        base       <= bus.addr[AW-1:0];
                        wdata      <= bus.bus_in;
                        last       <= req_last;
                        sram_addr  <= bus.addr[AW-1:0];
                        sram_wdata <= bus.bus_in[7:0];
                        sram_we    <= (WAIT_STATES == 0);
                    end else if (bus.mem_read && bus.mem_addr_ready) begin
                        state     <= RD;
                        base      <= bus.addr[AW-1:0];
                        size      <= bus.mem_size;
                        last      <= req_last;
                        rbuf      <= '0;
                        sram_addr <= bus.addr[AW-1:0];
                        sram_oe   <= 1'b1;
                    end
                end
                WR: begin
                    if (beat_end) begin
                        if (beat == last) begin
                            state   <= IDLE;
                            sram_we <= 1'b0;
                        end else begin
                            beat       <= beat_nx;
                            wcnt       <= '0;
                            sram_addr  <= addr_nx;
                            sram_wdata <= wdata[{beat_nx, 3'b000} +: 8];
                            sram_we    <= (WAIT_STATES == 0);
                        end
                    end else begin
                        wcnt    <= wcnt + 1'b1;
                        sram_we <= ((wcnt + 1'b1) == WLAST);
                    end
                end
                RD: begin
                    // A dropped read (trap) wins over any capture in the same cycle.
                    if (!bus.mem_read) begin
                        state   <= IDLE;
                        sram_oe <= 1'b0;
                    end else if (beat_end) begin
                        rbuf <= rword;
                        if (beat == last) begin
                            state   <= DONE;
                            sram_oe <= 1'b0;
                            mdr     <= 1'b1;
                            rdout   <= extend(size, rword);
                        end else begin
                            beat      <= beat_nx;
                            wcnt      <= '0;
                            sram_addr <= addr_nx;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    mdr   <= 1'b0;
                    rdout <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_data_ready = mdr;
    assign bus.bus_oe         = mdr;
    assign bus.bus_out        = rdout;
    assign bus.busy           = (state != IDLE);

endmodule
